// File: rtl/alu_exec_stage.sv
// Execute stage: decodes the ALU op, computes result/zero/illegal and queues
// them in a 2-entry valid/ready output buffer.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       count
);

  // Only a 2-entry buffer is supported; pointers are a single bit.
  localparam logic [1:0] Full = 2'(DEPTH);

  logic [WIDTH-1:0] op_res;
  logic             op_zero;
  logic             op_ill;

  logic [WIDTH-1:0] res_q  [2];
  logic             zero_q [2];
  logic             ill_q  [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (operation)
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b0010: op_res = a + b;
      4'b0110: op_res = a - b;
      default: op_ill = 1'b1;
    endcase
    op_zero = (op_res == '0);
  end

  assign in_ready  = (count_q < Full);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        zero_q[i] <= 1'b0;
        ill_q[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        res_q[wr_ptr_q]  <= op_res;
        zero_q[wr_ptr_q] <= op_zero;
        ill_q[wr_ptr_q]  <= op_ill;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Outputs come straight from the head register, never from a/b.
  assign result  = res_q[rd_ptr_q];
  assign zero    = zero_q[rd_ptr_q];
  assign illegal = ill_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [63:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;
  logic [1:0]  count;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        il;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] er;
    logic        ez;
    logic        eil;
  } vec_t;

  vec_t vt[10];

  alu_exec_stage #(.WIDTH(64), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic ent_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    ent_t e;
    e.il = 1'b0;
    if (op == 4'd0)      e.r = x & y;
    else if (op == 4'd1) e.r = x | y;
    else if (op == 4'd2) e.r = x + y;
    else if (op == 4'd6) e.r = x - y;
    else begin
      e.r  = 64'd0;
      e.il = 1'b1;
    end
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, compare outputs against the model, advance the
  // model over the edge, return at the following negedge.
  task automatic cycle(input logic iv, input logic [3:0] op, input logic [63:0] av,
                       input logic [63:0] bv, input logic ordy);
    logic psh, pp;
    in_valid  = iv;
    operation = op;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("result", result, mq[0].r);
      chk("zero", 64'(zero), 64'(mq[0].z));
      chk("illegal", 64'(illegal), 64'(mq[0].il));
    end
    psh = iv && (mq.size() < 2);
    pp  = ordy && (mq.size() != 0);
    @(posedge clk);
    if (pp)  void'(mq.pop_front());
    if (psh) mq.push_back(model(op, av, bv));
    @(negedge clk);
  endtask

  task automatic do_reset(input logic iv);
    reset    = 1'b1;
    in_valid = iv;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    in_valid = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
  endtask

  initial begin
    vt[0] = '{"add",      4'b0010, 64'd5,    64'd7,    64'd12,   1'b0, 1'b0};
    vt[1] = '{"sub_zero", 4'b0110, 64'd7,    64'd7,    64'd0,    1'b1, 1'b0};
    vt[2] = '{"and",      4'b0000, 64'hF0,   64'h3C,   64'h30,   1'b0, 1'b0};
    vt[3] = '{"or",       4'b0001, 64'hF0,   64'h0F,   64'hFF,   1'b0, 1'b0};
    vt[4] = '{"add_wrap", 4'b0010, '1,       64'd1,    64'd0,    1'b1, 1'b0};
    vt[5] = '{"sub_wrap", 4'b0110, 64'd0,    64'd1,    '1,       1'b0, 1'b0};
    vt[6] = '{"ill_1000", 4'b1000, 64'd9,    64'd9,    64'd0,    1'b1, 1'b1};
    vt[7] = '{"post_ill", 4'b0010, 64'd1,    64'd2,    64'd3,    1'b0, 1'b0};
    vt[8] = '{"ill_1111", 4'b1111, 64'd3,    64'd4,    64'd0,    1'b1, 1'b1};
    vt[9] = '{"and_zero", 4'b0000, 64'hAA,   64'h55,   64'd0,    1'b1, 1'b0};

    in_valid  = 1'b0;
    operation = 4'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Table: each result visible the cycle after acceptance.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vt[i].op, vt[i].av, vt[i].bv, 1'b1);
      chk({vt[i].name, "_valid"}, 64'(out_valid), 64'd1);
      chk(vt[i].name, result, vt[i].er);
      chk({vt[i].name, "_zero"}, 64'(zero), 64'(vt[i].ez));
      chk({vt[i].name, "_illegal"}, 64'(illegal), 64'(vt[i].eil));
    end
    cycle(1'b0, 4'd0, '0, '0, 1'b1);

    // Backpressure: third push held until space frees up.
    cycle(1'b1, 4'b0010, 64'd1, 64'd1, 1'b0);
    cycle(1'b1, 4'b0010, 64'd2, 64'd2, 1'b0);
    chk("bp_count_full", 64'(count), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    cycle(1'b1, 4'b0010, 64'd3, 64'd3, 1'b0);
    chk("bp_head_stable", result, 64'd2);
    cycle(1'b1, 4'b0010, 64'd3, 64'd3, 1'b1);
    chk("bp_second", result, 64'd4);
    cycle(1'b1, 4'b0010, 64'd3, 64'd3, 1'b1);
    chk("bp_third", result, 64'd6);
    chk("bp_count_one", 64'(count), 64'd1);
    cycle(1'b0, 4'd0, '0, '0, 1'b1);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Steady push+pop at count 1.
    cycle(1'b1, 4'b0010, 64'd100, 64'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'b0010, 64'(101 + i), 64'd0, 1'b1);
      chk("pp_count", 64'(count), 64'd1);
      chk("pp_result", result, 64'(101 + i));
    end
    cycle(1'b0, 4'd0, '0, '0, 1'b1);

    // Reset while full with in_valid high.
    cycle(1'b1, 4'b0010, 64'd10, 64'd10, 1'b0);
    cycle(1'b1, 4'b0010, 64'd20, 64'd20, 1'b0);
    chk("pre_rst_full", 64'(count), 64'd2);
    operation = 4'b0010;
    a         = 64'd50;
    b         = 64'd50;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, '0, '0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 5))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b0110;
        4: op = 4'(($urandom_range(0, 15)));
        default: op = 4'b0010;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), op, {$urandom, $urandom},
            ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, '0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
